// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package seg_pkg;

    localparam int DIGITS = 8;
    localparam int SCAN_W = 3;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        FREE = 2'd2
    } seg_state_e;

    // Bit width needed to hold values 0..n-1, never less than one bit.
    function automatic int seg_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/seg_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after start.
// With excl_last set, the slot just before start (the current owner) is skipped.
module seg_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   start,
    input  logic            excl_last,
    output logic            valid,
    output logic [IW-1:0]   idx
);

    logic [2*NREQ-1:0] req2;
    logic [NREQ-1:0]   rot;
    logic [IW:0]       sum;

    assign req2 = {req, req};
    assign rot  = req2[start +: NREQ];

    // Descending scan so the lowest rotated position wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        sum   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k] && !(excl_last && (k == NREQ - 1))) begin
                valid = 1'b1;
                sum   = {1'b0, start} + (IW+1)'(k);
                if (sum >= (IW+1)'(NREQ)) begin
                    sum = sum - (IW+1)'(NREQ);
                end
                idx = sum[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin sharing of the 8-digit display with minimum ownership and digit scan.
// Optional SEG_FRAME_SYNC_SWITCH_EN defers every grant change to the frame_p edge.
//   state | meaning
//   IDLE  | nobody owns the display, outputs zero
//   HOLD  | owned, minimum ownership timer running
//   FREE  | owned, timer expired, yields to any other request
module seg_display_arbiter
    import seg_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int SCAN_DIV = 131072,
    parameter int HOLD_CYC = 100000000
) (
    input  logic                       clk_100mhz,
    input  logic                       RSTN,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*32-1:0]         data_in,
    input  logic [NREQ*8-1:0]          les_in,
    input  logic [NREQ*8-1:0]          point_in,
    output logic [31:0]                data,
    output logic [7:0]                 les,
    output logic [7:0]                 point,
    output logic [2:0]                 scan,
    output logic [NREQ-1:0]            gnt,
    output logic [seg_clog2(NREQ)-1:0] owner_id,
    output logic                       busy,
    output logic                       switch_p,
    output logic                       frame_p
);

    localparam int IW = seg_clog2(NREQ);
    localparam int PW = seg_clog2(SCAN_DIV);
    localparam int HW = seg_clog2(HOLD_CYC);

    seg_state_e        state_q, state_d;
    logic [HW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic              busy_q, busy_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              switch_p_q, switch_p_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DIGITS-1:0] les_q, les_d;
    logic [DIGITS-1:0] point_q, point_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [SCAN_W-1:0] scan_q, scan_d;
    logic              frame_p_q, frame_p_d;

    logic              pick_valid;
    logic [IW-1:0]     pick_idx;
    logic [IW-1:0]     pick_start;
    logic              pick_excl;
    logic              owner_req;
    logic              take;
    logic              drop;
    logic              presc_tc;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        return (v == IW'(NREQ - 1)) ? '0 : v + 1'b1;
    endfunction

    assign pick_start = (state_q == IDLE) ? rr_ptr_q : wrap_inc(owner_q);
    assign pick_excl  = (state_q != IDLE);
    assign owner_req  = req[owner_q];

    seg_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req       (req),
        .start     (pick_start),
        .excl_last (pick_excl),
        .valid     (pick_valid),
        .idx       (pick_idx)
    );

    // Digit scan runs free of arbitration.
    always_comb begin
        presc_tc  = (presc_q == PW'(SCAN_DIV - 1));
        presc_d   = presc_tc ? '0 : presc_q + 1'b1;
        scan_d    = presc_tc ? scan_q + 1'b1 : scan_q;
        frame_p_d = presc_tc && (scan_q == SCAN_W'(DIGITS - 1));
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        busy_d   = busy_q;
        rr_ptr_d = rr_ptr_q;
        take     = 1'b0;
        drop     = 1'b0;

        case (state_q)
            IDLE: begin
                take = pick_valid;
            end
            HOLD: begin
                if (!owner_req) begin
                    take = pick_valid;
                    drop = !pick_valid;
                end else if (cnt_q == HW'(HOLD_CYC - 1)) begin
                    take = pick_valid;
                    if (!pick_valid) begin
                        state_d = FREE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FREE: begin
                take = pick_valid;
                drop = !pick_valid && !owner_req;
            end
            default: begin
                drop = 1'b1;
            end
        endcase

        if (take) begin
            state_d  = HOLD;
            cnt_d    = '0;
            owner_d  = pick_idx;
            busy_d   = 1'b1;
            rr_ptr_d = wrap_inc(pick_idx);
        end
        if (drop) begin
            state_d = IDLE;
            cnt_d   = '0;
            owner_d = '0;
            busy_d  = 1'b0;
        end

`ifdef SEG_FRAME_SYNC_SWITCH_EN
        // Hold the whole arbitration state until the frame boundary; the pick is
        // recomputed every cycle, so the change applied is the one valid then.
        if (((busy_d != busy_q) || (owner_d != owner_q)) && !frame_p_q) begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            owner_d  = owner_q;
            busy_d   = busy_q;
            rr_ptr_d = rr_ptr_q;
        end
`endif

        gnt_d = '0;
        if (busy_d) begin
            gnt_d[owner_d] = 1'b1;
        end
        switch_p_d = (gnt_d != gnt_q);

        data_d  = '0;
        les_d   = '0;
        point_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (busy_d && (owner_d == IW'(i))) begin
                data_d  = data_in[i*DATA_W +: DATA_W];
                les_d   = les_in[i*DIGITS +: DIGITS];
                point_d = point_in[i*DIGITS +: DIGITS];
            end
        end
    end

    always_ff @(posedge clk_100mhz or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            busy_q     <= 1'b0;
            gnt_q      <= '0;
            switch_p_q <= 1'b0;
            data_q     <= '0;
            les_q      <= '0;
            point_q    <= '0;
            presc_q    <= '0;
            scan_q     <= '0;
            frame_p_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            busy_q     <= busy_d;
            gnt_q      <= gnt_d;
            switch_p_q <= switch_p_d;
            data_q     <= data_d;
            les_q      <= les_d;
            point_q    <= point_d;
            presc_q    <= presc_d;
            scan_q     <= scan_d;
            frame_p_q  <= frame_p_d;
        end
    end

    assign data     = data_q;
    assign les      = les_q;
    assign point    = point_q;
    assign scan     = scan_q;
    assign gnt      = gnt_q;
    assign owner_id = owner_q;
    assign busy     = busy_q;
    assign switch_p = switch_p_q;
    assign frame_p  = frame_p_q;

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
Shares the board's 8-digit seven-segment display between NREQ independent requesters (e.g. CPU debug value, switch echo, counter monitor).
- Round-robin arbitration with a minimum ownership time, so the display never flickers between sources.
- Generates the digit-scan index itself.
- Drives the data/les/point/scan inputs of the existing Segment driver; sits between the requesting blocks and that driver in the top-level framework.

Parameters:
NREQ, 4, number of requesters (2..8)
SCAN_DIV, 131072, clk_100mhz cycles per digit step (~763 Hz per digit)
HOLD_CYC, 100000000, minimum ownership in cycles when contended (1 s); benches override with small values

Ports:
clk_100mhz  in   1         system clock, all state on rising edge
RSTN        in   1         asynchronous active-low reset
req         in   NREQ      per-requester display request, level
data_in     in   NREQ*32   requester i's hex value in bits [32*i+31:32*i]
les_in      in   NREQ*8    per-digit enable, 1 = digit lit
point_in    in   NREQ*8    per-digit decimal point, 1 = lit
data        out  32        value to Segment driver
les         out  8         digit enables to driver
point       out  8         decimal points to driver
scan        out  3         current digit index
gnt         out  NREQ      one-hot grant, all-zero when idle
owner_id    out  clog2(NREQ)  index of owner, 0 when idle
busy        out  1         display owned
switch_p    out  1         one-cycle pulse on every grant change, including idle->owned
frame_p     out  1         one-cycle pulse when scan wraps 7->0

Behaviour:
- Reset (RSTN low, asynchronous): state IDLE; all outputs 0; scan prescaler 0; hold counter 0; RR pointer 0.
- Scan: prescaler counts 0..SCAN_DIV-1. At the terminal count, scan increments modulo 8. frame_p is high in the cycle scan becomes 0. Scan runs independently of arbitration.
- Arbitration: round-robin pick among asserted req, searching from (last owner+1) mod NREQ. In IDLE, search from the RR pointer (reset 0).
- State IDLE:
  - any req -> grant pick at next edge, go to HOLD, hold counter = 0.
  - Grant latency: 1 cycle from req sampled to gnt/switch_p.
- State HOLD: hold counter increments each cycle. Checks are evaluated in this order:
  1. owner req low -> at next edge, grant the RR pick among the others (stay in HOLD, counter 0), else go to IDLE.
  2. counter == HOLD_CYC-1 -> switch to the RR pick if another req is pending (contended ownership is exactly HOLD_CYC cycles), else go to FREE.
- State FREE:
  - another req pending -> switch next edge to HOLD.
  - owner req low -> IDLE.
  - otherwise stay.
- Simultaneous owner drop and hold expiry: the drop path (rule 1) applies.
- Outputs data/les/point are registered muxes of the owner's inputs, updated every cycle (live), 1-cycle latency. Zero while idle.
- gnt, owner_id, busy and switch_p are registered and change on the same edge.
- Entering IDLE also asserts switch_p.
- req of a non-owner deasserting before it is granted is simply dropped; no request memory.

Optional Feature:
SEG_FRAME_SYNC_SWITCH_EN
- Defined: every grant change (grant, switch, release) is deferred until the edge where frame_p is high. State and hold counter freeze while the change is pending. A pending switch re-evaluates the RR pick at that edge. If the pending target has dropped req, the next pick is used, or IDLE if none.
- Undefined: changes take effect at the next edge as specified above.

Decomposition:
- Package seg_pkg: DIGITS=8, SCAN_W=3, DATA_W=32; state enum {IDLE, HOLD, FREE}; a clog2-based width function.
- Sub-module seg_rr_pick: combinational round-robin picker. Inputs: req vector, start index, exclude-owner flag. Outputs: valid and index.

Test Plan (NREQ=4, SCAN_DIV=4, HOLD_CYC=10):
- Reset: assert RSTN low mid-ownership, asynchronously -> gnt=0, data=0, scan=0, busy=0 immediately, with no clock edge needed.
- Single request: req=0010, data_in[1]=32'hDEADBEEF at cycle t -> at t+1: gnt=0010, owner_id=1, data=DEADBEEF, switch_p=1 for one cycle.
- Hold respected: req0 owns and req2 rises 3 cycles after the grant -> gnt stays 0001 until exactly 10 cycles after the grant, then becomes 0100.
- Fairness: req=1111 held -> grant order 0,1,2,3,0, each held exactly 10 cycles, with a switch_p pulse at each change.
- Early release: owner 1 drops req at hold count 2 while req3 is pending -> gnt=1000 next edge. With no other pending -> IDLE, outputs 0, switch_p pulse.
- Scan/feature: scan steps every 4 cycles, 7->0 with frame_p. With SEG_FRAME_SYNC_SWITCH_EN defined, a hold expiry mid-frame delays gnt until the frame_p edge.
